// File: rtl/accel_bus_slave.sv
// Bus slave for the CNN accelerator: streams weight/bias/pixel words into local
// memories, sequences compute start/done, and serves register and result reads.
module accel_bus_slave #(
    parameter int unsigned WEIGHT_DEPTH = 792,
    parameter int unsigned BIAS_DEPTH   = 16,
    parameter int unsigned PIXEL_DEPTH  = 6144
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] awaddr,
    input  logic        wvalid,
    input  logic [31:0] wdata,
    input  logic [31:0] araddr,
    input  logic        arvalid,
    output logic [31:0] rdata,
    output logic        interrupt_signal,
    output logic        weight_we,
    output logic        bias_we,
    output logic        pixel_we,
    output logic [9:0]  weight_addr,
    output logic [4:0]  bias_addr,
    output logic [12:0] pixel_addr,
    output logic [15:0] mem_wdata,
    output logic        start,
    input  logic        done,
    output logic [9:0]  result_raddr,
    input  logic [15:0] result_rdata
);

    localparam int unsigned WAW = 10;
    localparam int unsigned BAW = 5;
    localparam int unsigned PAW = 13;
    localparam int unsigned RAW = 10;
    localparam int unsigned DW  = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic            start_d;
    logic            pix_clr;

    logic [WAW-1:0]  wptr;
    logic [BAW-1:0]  bptr;
    logic [PAW-1:0]  pptr;

    logic [31:0]     rdata_q;
    logic            res_pend;

    // Address decode and acceptance qualifiers
    logic [15:0] wsel;
    logic [15:0] rsel;
    logic        weights_full;
    logic        bias_full;
    logic        pixels_full;
    logic        mem_open;
    logic        acc_w;
    logic        acc_b;
    logic        acc_p;
    logic        acc_any;
    logic        img_set;
    logic        irq_clr;
    logic        rd_result;
    logic        loaded_now;
    logic        unused_bits;

    assign wsel         = awaddr[31:16];
    assign rsel         = araddr[31:16];
    assign weights_full = (wptr == WAW'(WEIGHT_DEPTH));
    assign bias_full    = (bptr == BAW'(BIAS_DEPTH));
    assign pixels_full  = (pptr == PAW'(PIXEL_DEPTH));
    assign mem_open     = (state_q == IDLE) || (state_q == LOAD);
    assign acc_w        = wvalid && (wsel == 16'hd333) && mem_open && !weights_full;
    assign acc_b        = wvalid && (wsel == 16'hd444) && mem_open && !bias_full;
    assign acc_p        = wvalid && (wsel == 16'hd555) && mem_open && !pixels_full;
    assign acc_any      = acc_w || acc_b || acc_p;
    assign img_set      = wvalid && (wsel == 16'hd111) && wdata[0];
    assign irq_clr      = wvalid && (wsel == 16'hd222) && !wdata[0];
    assign rd_result    = arvalid && (rsel == 16'hd000);
    // A word landed last cycle: fullness is only acted on as it is reached
    assign loaded_now   = weight_we || bias_we || pixel_we;
    assign unused_bits  = ^{awaddr[15:0], wdata[31:16], araddr[15:10]};

    // Result memory address is presented in the same cycle as the read strobe
    assign result_raddr = (rst && rd_result) ? araddr[RAW-1:0] : '0;

    // Result reads show memory data in the cycle after the strobe, then hold
    assign rdata = res_pend ? {16'd0, result_rdata} : rdata_q;

    // Next-state and start decision
    always_comb begin
        state_d = state_q;
        start_d = 1'b0;
        pix_clr = 1'b0;
        case (state_q)
            IDLE: begin
                if (img_set) begin
                    state_d = LOAD;
                    pix_clr = 1'b1;
                end else if (acc_any) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (img_set) begin
                    pix_clr = 1'b1;
                end else if (weights_full && bias_full && pixels_full && loaded_now) begin
                    state_d = RUN;
                    start_d = 1'b1;
                end
            end
            RUN: begin
                if (done) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (img_set) begin
                    state_d = LOAD;
                    pix_clr = 1'b1;
                end else if (irq_clr) begin
                    state_d = LOAD;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register, start pulse and interrupt
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q          <= IDLE;
            start            <= 1'b0;
            interrupt_signal <= 1'b0;
        end else begin
            state_q          <= state_d;
            start            <= start_d;
            interrupt_signal <= (state_d == DONE);
        end
    end

    // Auto-incrementing memory write path, one-cycle registered strobes
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr        <= '0;
            bptr        <= '0;
            pptr        <= '0;
            weight_we   <= 1'b0;
            bias_we     <= 1'b0;
            pixel_we    <= 1'b0;
            weight_addr <= '0;
            bias_addr   <= '0;
            pixel_addr  <= '0;
            mem_wdata   <= '0;
        end else begin
            weight_we <= acc_w;
            bias_we   <= acc_b;
            pixel_we  <= acc_p;
            if (acc_any) begin
                mem_wdata <= wdata[DW-1:0];
            end
            if (acc_w) begin
                weight_addr <= wptr;
                wptr        <= wptr + WAW'(1);
            end
            if (acc_b) begin
                bias_addr <= bptr;
                bptr      <= bptr + BAW'(1);
            end
            if (pix_clr) begin
                pptr <= '0;
            end else if (acc_p) begin
                pixel_addr <= pptr;
                pptr       <= pptr + PAW'(1);
            end
        end
    end

    // Register read path; result reads capture memory data one cycle later
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata_q  <= '0;
            res_pend <= 1'b0;
        end else if (arvalid) begin
            res_pend <= rd_result;
            case (rsel)
                16'hd222: rdata_q <= {31'd0, interrupt_signal};
                16'hd111: rdata_q <= {28'd0, 2'(state_q), weights_full, pixels_full};
                default:  rdata_q <= '0;
            endcase
        end else if (res_pend) begin
            rdata_q  <= {16'd0, result_rdata};
            res_pend <= 1'b0;
        end
    end

endmodule

// File: tb/tb_accel_bus_slave.sv
// Scoreboard bench for accel_bus_slave: stimulus pushes expected memory writes,
// start cycles and read data; a negedge monitor pops and compares.
module tb_accel_bus_slave;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] awaddr = '0;
    logic        wvalid = 1'b0;
    logic [31:0] wdata = '0;
    logic [31:0] araddr = '0;
    logic        arvalid = 1'b0;
    logic [31:0] rdata;
    logic        interrupt_signal;
    logic        weight_we, bias_we, pixel_we;
    logic [9:0]  weight_addr;
    logic [4:0]  bias_addr;
    logic [12:0] pixel_addr;
    logic [15:0] mem_wdata;
    logic        start;
    logic        done = 1'b0;
    logic [9:0]  result_raddr;
    logic [15:0] result_rdata = '0;

    accel_bus_slave dut (
        .clk(clk), .rst(rst),
        .awaddr(awaddr), .wvalid(wvalid), .wdata(wdata),
        .araddr(araddr), .arvalid(arvalid), .rdata(rdata),
        .interrupt_signal(interrupt_signal),
        .weight_we(weight_we), .bias_we(bias_we), .pixel_we(pixel_we),
        .weight_addr(weight_addr), .bias_addr(bias_addr), .pixel_addr(pixel_addr),
        .mem_wdata(mem_wdata), .start(start), .done(done),
        .result_raddr(result_raddr), .result_rdata(result_rdata)
    );

    always #5 clk = ~clk;

    // Result memory: synchronous read, contents 16'h1231 ^ address
    always @(posedge clk) result_rdata <= 16'h1231 ^ {6'd0, result_raddr};

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic rd_seen = 1'b0;
    always @(posedge clk or negedge rst) begin
        if (!rst) rd_seen <= 1'b0;
        else      rd_seen <= arvalid;
    end

    typedef struct {
        int region;
        int addr;
        int data;
    } wexp_t;

    wexp_t       wq[$];
    logic [31:0] rq[$];
    int          sq[$];
    logic [31:0] last_rd = '0;
    int          tests = 0;
    int          fails = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic void push_w(input int r, input int a, input int d);
        wexp_t e;
        e.region = r;
        e.addr   = a;
        e.data   = d;
        wq.push_back(e);
    endfunction

    // Monitor: memory strobes, start pulses and read data
    always @(negedge clk) begin
        int nwe;
        int reg_a;
        int addr_a;
        wexp_t e;
        logic [31:0] er;
        int es;
        if (!rst) begin
            last_rd = '0;
        end else begin
            nwe = int'(weight_we) + int'(bias_we) + int'(pixel_we);
            reg_a = 0;
            addr_a = 0;
            if (weight_we) begin reg_a = 1; addr_a = int'(weight_addr); end
            if (bias_we)   begin reg_a = 2; addr_a = int'(bias_addr);   end
            if (pixel_we)  begin reg_a = 3; addr_a = int'(pixel_addr);  end
            if (nwe > 1) chk("we_onehot", 32'(nwe), 32'd1);
            if (nwe != 0) begin
                if (wq.size() == 0) begin
                    chk("we_unexpected", 32'(reg_a), 32'd0);
                end else begin
                    e = wq.pop_front();
                    chk("we_region", 32'(reg_a), 32'(e.region));
                    chk("we_addr", 32'(addr_a), 32'(e.addr));
                    chk("we_data", {16'd0, mem_wdata}, 32'(e.data));
                end
            end
            if (start) begin
                if (sq.size() == 0) begin
                    chk("start_unexpected", {31'd0, start}, 32'd0);
                end else begin
                    es = sq.pop_front();
                    chk("start_cycle", 32'(cyc), 32'(es));
                end
            end
            if (rd_seen && rq.size() != 0) begin
                er = rq.pop_front();
                chk("rdata", rdata, er);
                last_rd = er;
            end else begin
                chk("rdata_hold", rdata, last_rd);
            end
        end
    end

    task automatic io(input logic wv, input logic [31:0] wa, input logic [31:0] wd,
                      input logic rv, input logic [31:0] ra);
        wvalid  = wv;
        awaddr  = wa;
        wdata   = wd;
        arvalid = rv;
        araddr  = ra;
        @(negedge clk);
        wvalid  = 1'b0;
        arvalid = 1'b0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        io(1'b1, a, d, 1'b0, 32'd0);
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] exp);
        rq.push_back(exp);
        io(1'b0, 32'd0, 32'd0, 1'b1, a);
    endtask

    task automatic rd_res(input logic [31:0] a, input logic [9:0] exp_ra, input logic [31:0] exp);
        rq.push_back(exp);
        arvalid = 1'b1;
        araddr  = a;
        #1;
        chk("result_raddr", {22'd0, result_raddr}, {22'd0, exp_ra});
        @(negedge clk);
        arvalid = 1'b0;
    endtask

    task automatic pulse_done();
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
    endtask

    task automatic check_reset_out();
        arvalid = 1'b1;
        araddr  = 32'hd000_0007;
        #1;
        chk("rst_we", {29'd0, weight_we, bias_we, pixel_we}, 32'd0);
        chk("rst_addr", {4'd0, weight_addr, bias_addr, pixel_addr}, 32'd0);
        chk("rst_mem_wdata", {16'd0, mem_wdata}, 32'd0);
        chk("rst_start_irq", {30'd0, start, interrupt_signal}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_result_raddr", {22'd0, result_raddr}, 32'd0);
        arvalid = 1'b0;
    endtask

    initial begin
        #1 rst = 1'b0;
        #2 check_reset_out();
        repeat (3) @(negedge clk);
        rst = 1'b1;
        rd(32'hd111_0000, 32'd0);

        // First load: weights every 5 cycles, then overflow attempt
        for (int i = 0; i < 792; i++) begin
            push_w(1, i, i);
            wr(32'hd333_0000, 32'(i));
            repeat (4) @(negedge clk);
        end
        wr(32'hd333_0000, 32'd792);
        rd(32'hd111_0000, 32'd6);

        for (int i = 0; i < 16; i++) begin
            push_w(2, i, 16'hb000 + i);
            wr(32'hd444_00ff, 32'hffff_b000 + 32'(i));
        end
        wr(32'hd444_0000, 32'h55);
        wr(32'hd999_0000, 32'd1);
        wr(32'hd222_0000, 32'd0);
        pulse_done();
        rd(32'hd111_0000, 32'd6);

        // 100 pixels, one with a concurrent interrupt-register read
        for (int i = 0; i < 100; i++) begin
            push_w(3, i, i);
            if (i == 50) begin
                rq.push_back(32'd0);
                io(1'b1, 32'hd555_0000, 32'(i), 1'b1, 32'hd222_0000);
            end else begin
                wr(32'hd555_0000, 32'(i));
            end
        end
        repeat (3) @(negedge clk);

        // Reset mid-load
        rst = 1'b0;
        #2 check_reset_out();
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // Reload: first write on the first edge after reset, with a state read
        push_w(1, 0, 0);
        rq.push_back(32'd0);
        io(1'b1, 32'hd333_0000, 32'd0, 1'b1, 32'hd111_0000);
        for (int i = 1; i < 792; i++) begin
            push_w(1, i, i);
            wr(32'hd333_0000, 32'(i));
        end
        for (int i = 0; i < 16; i++) begin
            push_w(2, i, i + 7);
            wr(32'hd444_0000, 32'(i + 7));
        end
        for (int i = 0; i < 6144; i++) begin
            push_w(3, i, i);
            if (i == 6143) sq.push_back(cyc + 2);
            wr(32'hd555_0000, 32'(i));
        end
        wr(32'hd555_0000, 32'h77);
        wr(32'hd333_0000, 32'h78);
        rd(32'hd111_0000, 32'd11);
        rd(32'hd222_0000, 32'd0);

        // Compute complete, interrupt handshake
        pulse_done();
        chk("irq_set", {31'd0, interrupt_signal}, 32'd1);
        rd(32'hd222_0000, 32'd1);
        rd(32'hd111_0000, 32'd15);
        wr(32'hd222_0000, 32'd0);
        chk("irq_clear", {31'd0, interrupt_signal}, 32'd0);
        rd(32'hd111_0000, 32'd7);
        rd(32'hd222_0000, 32'd0);

        // Next image: pixel pointer restarts, weights/bias kept
        wr(32'hd111_0000, 32'd1);
        rd(32'hd111_0000, 32'd6);
        push_w(3, 0, 16'habcd);
        wr(32'hd555_0000, 32'h0000_abcd);

        // Result and unmapped reads
        rd_res(32'hd000_0005, 10'd5, 32'h0000_1234);
        rd(32'hd999_0000, 32'd0);
        rd_res(32'hd000_03ff, 10'h3ff, 32'h0000_11ce);
        rd_res(32'hd000_fc05, 10'd5, 32'h0000_1234);
        repeat (2) @(negedge clk);

        for (int i = 1; i < 6144; i++) begin
            push_w(3, i, i);
            if (i == 6143) sq.push_back(cyc + 2);
            wr(32'hd555_0000, 32'(i));
        end
        repeat (2) @(negedge clk);

        // done and interrupt clear together in RUN: done wins
        done = 1'b1;
        wr(32'hd222_0000, 32'd0);
        done = 1'b0;
        chk("done_wins_irq", {31'd0, interrupt_signal}, 32'd1);
        rd(32'hd222_0000, 32'd1);
        rd(32'hd111_0000, 32'd15);

        repeat (5) @(negedge clk);
        chk("wq_drained", 32'(wq.size()), 32'd0);
        chk("start_drained", 32'(sq.size()), 32'd0);
        chk("rq_drained", 32'(rq.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
